rs_frame_serializer: RTL

Upstream neighbour of the channel error injector. It takes Reed-Solomon codeword symbols (parallel, valid/ready handshake) from the encoder and emits a framed serial bitstream on data_out at one bit per clock. Each frame is a fixed preamble followed by FRAME_SYMS symbols, MSB first. This stream feeds the channel's serial data input directly, and the preamble lets the downstream deserializer acquire symbol alignment.

---
 rtl/rs_link_pkg.sv | 22 ++
 rtl/rs_sym_buffer.sv | 56 +++++
 rtl/rs_frame_serializer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/rs_link_pkg.sv
// Shared framing definitions for the RS serial link. The serializer and the
// downstream deserializer both import this, so framing matches by construction.
package rs_link_pkg;

  localparam int SYM_W      = 4;      // bits per RS symbol, GF(2^4)
  localparam int FRAME_SYMS = 15;     // RS(15,11) codeword length
  localparam int PRE_W      = 8;      // preamble length in bits

  localparam logic [PRE_W-1:0] PREAMBLE = 8'hA5;  // sent MSB first
  localparam logic             IDLE_BIT = 1'b0;   // line level between frames

  // One bit counter is shared by the preamble and symbol phases.
  localparam int BIT_CNT_W = $clog2((PRE_W > SYM_W) ? PRE_W : SYM_W);
  localparam int SYM_CNT_W = $clog2(FRAME_SYMS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2
  } ser_state_e;

endpackage

// File: rtl/rs_sym_buffer.sv
// One-entry valid/ready holding register between the RS encoder and the
// serializer shift register. Ready never looks ahead: a full buffer refuses
// input until the serializer has taken its contents.
module rs_sym_buffer
  import rs_link_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst,
  input  logic [SYM_W-1:0] sym_in,
  input  logic             sym_valid,
  output logic             sym_ready,
  input  logic             load,
  output logic             buf_full,
  output logic [SYM_W-1:0] buf_data
);

  logic             full_q, full_d;
  logic [SYM_W-1:0] data_q, data_d;
  logic             accept;

  assign sym_ready = !full_q;
  assign accept    = sym_valid && !full_q;
  assign buf_full  = full_q;
  assign buf_data  = data_q;

  // Next buffer contents: load empties it, an accepted symbol fills it.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (load) begin
      full_d = 1'b0;
    end
    if (accept) begin
      full_d = 1'b1;
      data_d = sym_in;
    end
  end

  // Full flag register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      full_q <= 1'b0;
    end else begin
      full_q <= full_d;
    end
  end

  // Payload register.
  // NOTE: the payload is only meaningful while full_q is set, so it carries no reset value.
  always_ff @(posedge clk_in) begin
    data_q <= data_d;
  end

endmodule

// File: rtl/rs_frame_serializer.sv
// Frames RS codeword symbols into a serial bitstream: PREAMBLE followed by
// FRAME_SYMS symbols, MSB first, one bit per clock. A missing symbol at a
// symbol boundary aborts the frame with an underrun pulse.
module rs_frame_serializer
  import rs_link_pkg::*;
(
  input  logic             clk_in,
  input  logic             rst,
  input  logic [SYM_W-1:0] sym_in,
  input  logic             sym_valid,
  output logic             sym_ready,
  output logic             data_out,
  output logic             frame_active,
  output logic             frame_done,
  output logic             underrun
);

  localparam logic [BIT_CNT_W-1:0] BIT_ONE  = BIT_CNT_W'(1);
  localparam logic [BIT_CNT_W-1:0] PRE_LAST = BIT_CNT_W'(PRE_W - 1);
  localparam logic [BIT_CNT_W-1:0] SYM_LAST = BIT_CNT_W'(SYM_W - 1);
  localparam logic [SYM_CNT_W-1:0] SYM_ONE  = SYM_CNT_W'(1);
  localparam logic [SYM_CNT_W-1:0] FRM_LAST = SYM_CNT_W'(FRAME_SYMS - 1);

  ser_state_e           state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [SYM_CNT_W-1:0] sym_cnt_q, sym_cnt_d;
  logic [SYM_W-1:0]     shift_q, shift_d;
  logic                 data_q, data_d;
  logic                 done_q, done_d;
  logic                 underrun_q, underrun_d;

  logic                 buf_load;
  logic                 buf_full;
  logic [SYM_W-1:0]     buf_data;
  logic [PRE_W-1:0]     pre_rest;

  rs_sym_buffer u_buf (
    .clk_in    (clk_in),
    .rst       (rst),
    .sym_in    (sym_in),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .load      (buf_load),
    .buf_full  (buf_full),
    .buf_data  (buf_data)
  );

  assign data_out     = data_q;
  assign frame_active = (state_q != IDLE);
  assign frame_done   = done_q;
  assign underrun     = underrun_q;

  // Next-state, counters, shift register and registered line outputs.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    sym_cnt_d  = sym_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    done_d     = 1'b0;
    underrun_d = 1'b0;
    buf_load   = 1'b0;
    pre_rest   = '0;

    unique case (state_q)
      IDLE: begin
        data_d = IDLE_BIT;
        if (buf_full) begin
          data_d    = PREAMBLE[PRE_W-1];
          bit_cnt_d = '0;
          state_d   = PRE;
        end
      end

      PRE: begin
        if (bit_cnt_q == PRE_LAST) begin
          // The buffer filled before PRE was entered and cannot drain during PRE.
          buf_load  = 1'b1;
          shift_d   = buf_data;
          data_d    = buf_data[SYM_W-1];
          sym_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = DATA;
        end else begin
          // Preamble bits still to send, next one aligned to the MSB.
          pre_rest  = PREAMBLE << (bit_cnt_q + BIT_ONE);
          data_d    = pre_rest[PRE_W-1];
          bit_cnt_d = bit_cnt_q + BIT_ONE;
        end
      end

      DATA: begin
        if (bit_cnt_q == SYM_LAST) begin
          bit_cnt_d = '0;
          if (sym_cnt_q == FRM_LAST) begin
            data_d    = IDLE_BIT;
            done_d    = 1'b1;
            sym_cnt_d = '0;
            state_d   = IDLE;
          end else if (buf_full) begin
            buf_load  = 1'b1;
            shift_d   = buf_data;
            data_d    = buf_data[SYM_W-1];
            sym_cnt_d = sym_cnt_q + SYM_ONE;
          end else begin
            data_d     = IDLE_BIT;
            underrun_d = 1'b1;
            sym_cnt_d  = '0;
            state_d    = IDLE;
          end
        end else begin
          data_d    = shift_q[SYM_W-2];
          shift_d   = shift_q << 1;
          bit_cnt_d = bit_cnt_q + BIT_ONE;
        end
      end

      default: begin
        state_d = IDLE;
        data_d  = IDLE_BIT;
      end
    endcase
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      sym_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= IDLE_BIT;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      sym_cnt_q  <= sym_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
    end
  end

endmodule
